// File: rtl/arith_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and sizing helpers.
`default_nettype none

package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter needs at least one bit even when the operand is a single digit.
  function automatic int cnt_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  function automatic bit split_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_serial_adder_if.sv
// Start/done handshake and operand/result bundle for the digit-serial adder.
`default_nettype none

interface digit_serial_adder_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );

endinterface

`default_nettype wire

// File: rtl/full_adder.sv
// One-bit full adder, the cell of the digit ripple chain.
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/rca_n.sv
// DIGIT-bit combinational ripple-carry adder; also exposes the carry into its MSB.
`default_nettype none

module rca_n #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // Each stage owns its carry nets so the chain is not one self-referencing vector.
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_chain
      assign ci = g_bit[i-1].co;
    end
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (ci),
      .sum  (sum[i]),
      .cout (co)
    );
  end

  assign cout  = g_bit[DIGIT-1].co;
  assign c_msb = g_bit[DIGIT-1].ci;

endmodule

`default_nettype wire

// File: rtl/digit_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, DIGIT bits per clock through a registered carry.
// Subtraction is built only when SUBTRACT_EN is defined; otherwise sub is ignored.
`default_nettype none

module digit_serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  digit_serial_adder_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  if (!split_ok(WIDTH, DIGIT)) begin : g_bad_split
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;

`ifdef SUBTRACT_EN
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub ? 1'b1   : bus.cin;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_load     = bus.b;
  assign carry_load = bus.cin;
`endif

  assign last = (cnt_reg == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands shift down so the active digit always sits in the low bits.
  rca_n #(.DIGIT(DIGIT)) u_rca (
    .a     (a_reg[DIGIT-1:0]),
    .b     (b_reg[DIGIT-1:0]),
    .cin   (carry_reg),
    .sum   (dig_sum),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (load) begin
      a_reg     <= bus.a;
      b_reg     <= b_load;
      carry_reg <= carry_load;
      cnt_reg   <= '0;
    end else if (step) begin
      a_reg     <= a_reg >> DIGIT;
      b_reg     <= b_reg >> DIGIT;
      carry_reg <= dig_cout;
      cnt_reg   <= cnt_reg + CW'(1);
      for (int i = 0; i < N; i++) begin
        if (cnt_reg == CW'(i)) s_reg[i*DIGIT +: DIGIT] <= dig_sum;
      end
      if (last) begin
        cout_reg <= dig_cout;
        ovf_reg  <= dig_cmsb ^ dig_cout;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.s    = s_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;

endmodule

`default_nettype wire
